// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 adder pipeline.
// Provides the raw IEEE-754 single layout, the per-operand class enum,
// and the registered payload carried from the unpack stage to the align stage.
package fp_pkg;

  localparam int          EXP_W    = 8;
  localparam int          MANT_W   = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  // Raw IEEE-754 single-precision layout, MSB first.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // NORMAL is encoded as 0 so a cleared payload decodes to "no flag set".
  typedef enum logic [2:0] {
    NORMAL = 3'd0,
    ZERO   = 3'd1,
    SUB    = 3'd2,
    INF    = 3'd3,
    NAN    = 3'd4
  } fp_class_t;

  // One unpacked operand as registered by the entry stage.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              hidden;
    fp_class_t         cls;
  } unpacked_t;

  // One buffer entry: both operands plus the magnitude compare.
  typedef struct packed {
    unpacked_t a;
    unpacked_t b;
    logic      age_b;
  } pair_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack/classify of one IEEE-754 single operand.
// Ports:
//   i_op   in  32  raw operand
//   o_unp  out     sign, raw biased exponent, fraction (hidden bit excluded),
//                  hidden bit, and class (NORMAL/ZERO/SUB/INF/NAN)
// With FLUSH_SUBNORMAL=1 a subnormal is reported as a signed zero: fraction
// forced to 0 and class ZERO; the exponent is already 0 in that case.
module fp_classify
  import fp_pkg::*;
#(
  parameter bit FLUSH_SUBNORMAL = 1'b0
) (
  input  logic [31:0] i_op,
  output unpacked_t   o_unp
);

  fp32_t w_op;
  logic  w_exp_max;
  logic  w_exp_zero;
  logic  w_mant_zero;
  logic  w_flush;

  assign w_op        = i_op;
  assign w_exp_max   = (w_op.exp == EXP_MAX);
  assign w_exp_zero  = (w_op.exp == '0);
  assign w_mant_zero = (w_op.mant == '0);
  assign w_flush     = FLUSH_SUBNORMAL && w_exp_zero && !w_mant_zero;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the if-chain can leave it unassigned (latch).
    o_unp        = '0;
    o_unp.sign   = w_op.sign;
    o_unp.exp    = w_op.exp;
    o_unp.mant   = w_flush ? '0 : w_op.mant;
    o_unp.hidden = !w_exp_max && !w_exp_zero;
    o_unp.cls    = NORMAL;
    if (w_exp_max) begin
      o_unp.cls = w_mant_zero ? INF : NAN;
    end else if (w_exp_zero) begin
      o_unp.cls = (w_mant_zero || FLUSH_SUBNORMAL) ? ZERO : SUB;
    end
  end

endmodule

// File: rtl/fp_unpack_stage.sv
// Registered operand-entry stage of the FP32 adder pipeline.
// Splits A and B into sign/exponent/fraction, classifies each, computes
// |A| >= |B|, and hands the result to the align stage through a 2-entry
// skid buffer (main register drives the outputs, skid catches one extra pair).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          operand pair handshake (in_ready is registered)
//   A, B                       raw IEEE-754 singles
//   out_valid/out_ready        unpacked pair handshake
//   signX, exponentX,
//   mantissaX, hiddenX         unpacked fields per operand
//   Xinf, XNaN, Xsub, Xzero    class flags, at most one set per operand
//   AgeB                       A[30:0] >= B[30:0] (flushed subnormals count as 0)
module fp_unpack_stage
  import fp_pkg::*;
#(
  parameter bit FLUSH_SUBNORMAL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        signA,
  output logic        signB,
  output logic [7:0]  exponentA,
  output logic [7:0]  exponentB,
  output logic [22:0] mantissaA,
  output logic [22:0] mantissaB,
  output logic        hiddenA,
  output logic        hiddenB,
  output logic        Ainf,
  output logic        Binf,
  output logic        ANaN,
  output logic        BNaN,
  output logic        Asub,
  output logic        Bsub,
  output logic        Azero,
  output logic        Bzero,
  output logic        AgeB
);

  unpacked_t w_a;
  unpacked_t w_b;
  pair_t     w_in_pair;
  logic      w_accept;
  logic      w_drain;

  pair_t     r_main;
  pair_t     r_skid;
  logic      r_main_valid;
  logic      r_skid_valid;

  fp_classify #(.FLUSH_SUBNORMAL(FLUSH_SUBNORMAL)) u_cls_a (
    .i_op  (A),
    .o_unp (w_a)
  );

  fp_classify #(.FLUSH_SUBNORMAL(FLUSH_SUBNORMAL)) u_cls_b (
    .i_op  (B),
    .o_unp (w_b)
  );

  // The classifier already zeroes a flushed fraction, so comparing the
  // unpacked {exp, mant} equals A[30:0] >= B[30:0] without flush and treats
  // a flushed subnormal as 0 with it.
  assign w_in_pair.a     = w_a;
  assign w_in_pair.b     = w_b;
  assign w_in_pair.age_b = ({w_a.exp, w_a.mant} >= {w_b.exp, w_b.mant});

  // in_ready depends only on the skid register, never on out_ready.
  assign in_ready = !r_skid_valid;
  assign w_accept = in_valid && !r_skid_valid;
  assign w_drain  = r_main_valid && out_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
    end else if (r_skid_valid) begin
      // Full: nothing is accepted; a drain promotes the skid entry.
      if (w_drain) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid || w_drain) begin
        r_main       <= w_in_pair;
        r_main_valid <= 1'b1;
      end else begin
        r_skid_valid <= 1'b1;
      end
    end else if (w_drain) begin
      r_main_valid <= 1'b0;
    end
  end

  // NOTE: skid data is not reset; it is only ever read while r_skid_valid
  // is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (w_accept && r_main_valid && !w_drain) begin
      r_skid <= w_in_pair;
    end
  end

  assign out_valid = r_main_valid;

  assign signA     = r_main.a.sign;
  assign signB     = r_main.b.sign;
  assign exponentA = r_main.a.exp;
  assign exponentB = r_main.b.exp;
  assign mantissaA = r_main.a.mant;
  assign mantissaB = r_main.b.mant;
  assign hiddenA   = r_main.a.hidden;
  assign hiddenB   = r_main.b.hidden;
  assign AgeB      = r_main.age_b;

  assign Ainf  = (r_main.a.cls == INF);
  assign Binf  = (r_main.b.cls == INF);
  assign ANaN  = (r_main.a.cls == NAN);
  assign BNaN  = (r_main.b.cls == NAN);
  assign Asub  = (r_main.a.cls == SUB);
  assign Bsub  = (r_main.b.cls == SUB);
  assign Azero = (r_main.a.cls == ZERO);
  assign Bzero = (r_main.b.cls == ZERO);

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Self-checking bench for fp_unpack_stage. Two instances share all inputs:
// u_dut0 with FLUSH_SUBNORMAL=0 and u_dut1 with FLUSH_SUBNORMAL=1. Expected
// outputs for both are pushed to queues on each accepted pair and popped when
// the stage delivers a pair.
module tb_fp_unpack_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;

  always #5 clk = ~clk;

  // Instance 0 outputs (no flush)
  logic ir0, ov0, sA0, sB0, hA0, hB0, agb0;
  logic ainf0, binf0, anan0, bnan0, asub0, bsub0, azero0, bzero0;
  logic [7:0]  eA0, eB0;
  logic [22:0] mA0, mB0;
  // Instance 1 outputs (flush)
  logic ir1, ov1, sA1, sB1, hA1, hB1, agb1;
  logic ainf1, binf1, anan1, bnan1, asub1, bsub1, azero1, bzero1;
  logic [7:0]  eA1, eB1;
  logic [22:0] mA1, mB1;

  fp_unpack_stage #(.FLUSH_SUBNORMAL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
    .A(A), .B(B), .out_valid(ov0), .out_ready(out_ready),
    .signA(sA0), .signB(sB0), .exponentA(eA0), .exponentB(eB0),
    .mantissaA(mA0), .mantissaB(mB0), .hiddenA(hA0), .hiddenB(hB0),
    .Ainf(ainf0), .Binf(binf0), .ANaN(anan0), .BNaN(bnan0),
    .Asub(asub0), .Bsub(bsub0), .Azero(azero0), .Bzero(bzero0), .AgeB(agb0)
  );

  fp_unpack_stage #(.FLUSH_SUBNORMAL(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .A(A), .B(B), .out_valid(ov1), .out_ready(out_ready),
    .signA(sA1), .signB(sB1), .exponentA(eA1), .exponentB(eB1),
    .mantissaA(mA1), .mantissaB(mB1), .hiddenA(hA1), .hiddenB(hB1),
    .Ainf(ainf1), .Binf(binf1), .ANaN(anan1), .BNaN(bnan1),
    .Asub(asub1), .Bsub(bsub1), .Azero(azero1), .Bzero(bzero1), .AgeB(agb1)
  );

  // Observation vector: {valid, A{sign,exp,mant,hidden,inf,nan,sub,zero}, B{...}, AgeB}
  logic [75:0] obs0, obs1;
  logic [7:0]  flags0, flags1;
  assign obs0 = {ov0, sA0, eA0, mA0, hA0, ainf0, anan0, asub0, azero0,
                 sB0, eB0, mB0, hB0, binf0, bnan0, bsub0, bzero0, agb0};
  assign obs1 = {ov1, sA1, eA1, mA1, hA1, ainf1, anan1, asub1, azero1,
                 sB1, eB1, mB1, hB1, binf1, bnan1, bsub1, bzero1, agb1};
  assign flags0 = {ainf0, binf0, anan0, bnan0, asub0, bsub0, azero0, bzero0};
  assign flags1 = {ainf1, binf1, anan1, bnan1, asub1, bsub1, azero1, bzero1};

  int n_checks = 0;
  int n_err    = 0;
  int n_out    = 0;
  logic [75:0] q0[$];
  logic [75:0] q1[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [36:0] model_op(input logic [31:0] x, input bit flush);
    logic [7:0]  e;
    logic [22:0] m;
    logic        hid, inf, nan, sub, zero;
    e    = x[30:23];
    m    = x[22:0];
    hid  = (e != 8'h00) && (e != 8'hFF);
    inf  = (e == 8'hFF) && (m == 0);
    nan  = (e == 8'hFF) && (m != 0);
    sub  = (e == 8'h00) && (m != 0) && !flush;
    zero = (e == 8'h00) && ((m == 0) || flush);
    if (flush && e == 8'h00) m = '0;
    return {x[31], e, m, hid, inf, nan, sub, zero};
  endfunction

  function automatic logic [75:0] model_pair(input logic [31:0] a, input logic [31:0] b, input bit flush);
    logic [30:0] ma, mb;
    ma = (flush && a[30:23] == 8'h00) ? 31'd0 : a[30:0];
    mb = (flush && b[30:23] == 8'h00) ? 31'd0 : b[30:0];
    return {1'b1, model_op(a, flush), model_op(b, flush), ma >= mb};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:0] = 31'd0;
      1: begin x[30:23] = 8'h00; x[22:0] = 23'($urandom_range(1, 23'h7FFFFF)); end
      2: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
      3: begin x[30:23] = 8'hFF; x[22:0] = 23'($urandom_range(1, 23'h7FFFFF)); end
      default: ;
    endcase
    return x;
  endfunction

  // One clock: handshakes are evaluated on the falling edge (inputs and
  // outputs settled), then the bench steps to just after the rising edge.
  task automatic tick(output bit acc);
    acc = 1'b0;
    @(negedge clk);
    if (!reset) begin
      if (in_valid && ir0) begin
        q0.push_back(model_pair(A, B, 1'b0));
        q1.push_back(model_pair(A, B, 1'b1));
        acc = 1'b1;
      end
      if (ov0 && out_ready) begin
        n_out++;
        check("sb_nonempty", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          check("sb_flush0", obs0, q0.pop_front());
          check("sb_flush1", obs1, q1.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    bit unused_acc;
    tick(unused_acc);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    int          n0;
    logic [75:0] snap;
    logic [31:0] pa[3];
    logic [31:0] pb[3];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_valid", ov0, 0);
    check("rst_ready", ir0, 1);
    check("rst_out0", obs0, 0);
    check("rst_out1", obs1, 0);

    // 1: normal operands
    A = 32'h3F800000; B = 32'hC0000000; in_valid = 1'b1;
    tick(acc); in_valid = 1'b0;
    check("t1_acc", acc, 1);
    check("t1_valid", ov0, 1);
    check("t1_opA", {sA0, eA0, mA0, hA0}, {1'b0, 8'h7F, 23'd0, 1'b1});
    check("t1_opB", {sB0, eB0, mB0, hB0}, {1'b1, 8'h80, 23'd0, 1'b1});
    check("t1_flags_agb", {flags0, agb0}, 9'd0);

    // 2: Inf vs NaN
    A = 32'h7F800000; B = 32'h7FC00000; in_valid = 1'b1;
    tick(acc); in_valid = 1'b0;
    check("t2_flags", flags0, 8'b1001_0000);
    check("t2_hid_agb", {hA0, hB0, agb0}, 3'b000);

    // 3: -0 vs smallest subnormal, both flush settings
    A = 32'h80000000; B = 32'h00000001; in_valid = 1'b1;
    tick(acc); in_valid = 1'b0;
    check("t3_flags_nf", flags0, 8'b0000_0110);
    check("t3_fields_nf", {sA0, mB0, agb0}, {1'b1, 23'd1, 1'b0});
    check("t3_flags_f", flags1, 8'b0000_0011);
    check("t3_fields_f", {sA1, mB1, agb1}, {1'b1, 23'd0, 1'b1});
    cyc();
    check("t3_drained", q0.size(), 0);

    // 4: backpressure with three pairs
    for (int i = 0; i < 3; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
    out_ready = 1'b0; in_valid = 1'b1;
    A = pa[0]; B = pb[0]; tick(acc); check("t4_p0_acc", acc, 1);
    A = pa[1]; B = pb[1]; tick(acc); check("t4_p1_acc", acc, 1);
    check("t4_ready_low", ir0, 0);
    check("t4_main_p0", obs0, model_pair(pa[0], pb[0], 1'b0));
    snap = obs0;
    A = pa[2]; B = pb[2];
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check("t4_p2_held", acc, 0);
      check("t4_stable", obs0, snap);
    end
    out_ready = 1'b1; n0 = n_out;
    tick(acc); check("t4_rel_no_acc", acc, 0);
    tick(acc); check("t4_p2_acc", acc, 1);
    in_valid = 1'b0;
    cyc();
    check("t4_three_out", n_out - n0, 3);
    check("t4_drained", q0.size(), 0);

    // 5: sustained stream, then random toggling
    n0 = n_out; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      A = rand_op();
      B = ($urandom_range(0, 3) == 0) ? A : rand_op();
      tick(acc);
      check("t5_acc", acc, 1);
    end
    in_valid = 1'b0;
    cyc();
    check("t5_count", n_out - n0, 16);
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      A = rand_op();
      B = ($urandom_range(0, 3) == 0) ? A : rand_op();
      tick(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && q0.size() != 0; k++) cyc();
    check("t5_drained", q0.size(), 0);

    // 6: reset while both entries are full
    out_ready = 1'b0; in_valid = 1'b1;
    A = rand_op(); B = rand_op(); cyc();
    A = rand_op(); B = rand_op(); cyc();
    check("t6_full", ir0, 0);
    in_valid = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    q0.delete(); q1.delete();
    check("t6_valid", ov0, 0);
    check("t6_ready", ir0, 1);
    check("t6_out0", obs0, 0);
    check("t6_out1", obs1, 0);
    A = 32'h00000002; B = 32'h3F800000; in_valid = 1'b1; out_ready = 1'b1;
    tick(acc); in_valid = 1'b0;
    check("t6_acc", acc, 1);
    n0 = n_out;
    cyc();
    check("t6_first_out", n_out - n0, 1);
    check("t6_drained", q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fp_unpack_stage.md
Name: fp_unpack_stage

Overview:
- Registered operand-entry stage of the FP32 adder pipeline; the inverse of the pack step.
- Accepts raw IEEE-754 single-precision operand pairs A/B over a valid/ready handshake.
- Splits each operand into sign/exponent/mantissa, classifies it, and presents the results to the align stage through a 2-entry skid buffer.
- Drives the bus control flags (Ainf, Binf, ANaN, BNaN, Asub, Bsub, Azero, Bzero), which no other stage produces.

Parameters:
- FLUSH_SUBNORMAL, 0: when 1, subnormal inputs are emitted as signed zero (mantissa forced to 0, Zero flag set, Sub flag clear, sign preserved).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept a pair
- A  in  32  operand A, IEEE-754 single
- B  in  32  operand B, IEEE-754 single
- out_valid  out  1  unpacked pair valid
- out_ready  in  1  downstream (align) accepts
- signA, signB  out  1 each  operand signs
- exponentA, exponentB  out  8 each  biased exponents, raw
- mantissaA, mantissaB  out  23 each  fraction fields, hidden bit excluded
- hiddenA, hiddenB  out  1 each  implicit leading bit: 1 iff exponent is neither 0 nor 255
- Ainf, Binf, ANaN, BNaN, Asub, Bsub, Azero, Bzero  out  1 each  class flags
- AgeB  out  1  |A| >= |B|, compared on bits [30:0]

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset (sampled high at a clk edge):
  - both buffer entries invalid; out_valid=0; in_ready=1.
  - all data and flag outputs = 0.
  - Takes priority over any handshake in the same cycle; an in-flight pair is dropped silently.
- Handshake:
  - Transfer in when in_valid & in_ready at a clk edge.
  - Transfer out when out_valid & out_ready.
  - in_valid is never required to wait for in_ready.
- Latency and throughput: 1 cycle from accepted input to out_valid. One pair per cycle sustained while out_ready=1.
- Buffer: main register (drives outputs) plus skid register.
  - in_ready = !skid_valid, from a register; no combinational path from out_ready.
  - Input accepted while main empty or draining this cycle -> goes to main.
  - Input accepted while main full and not draining -> goes to skid.
  - Main drains while skid holds data -> skid moves to main in the same edge; skid cleared.
  - Simultaneous accept and drain with skid empty -> new pair replaces main; out_valid stays 1.
  - Both entries full -> in_ready=0; in_valid ignored.
- Ordering: strict FIFO order, no drops or duplicates.
- Output stability: outputs hold stable while out_valid & !out_ready.
- Classification, per operand (e = exponent, m = fraction):
  - e=255, m=0 -> Inf.
  - e=255, m!=0 -> NaN (quiet and signalling alike).
  - e=0, m=0 -> Zero.
  - e=0, m!=0 -> Sub, unless FLUSH_SUBNORMAL=1 (see Parameters).
  - Otherwise normal: no flag set.
  - At most one flag per operand.
- Sign handling: -0 keeps sign=1. NaN sign passes through unchanged.
- AgeB:
  - Unsigned compare of A[30:0] >= B[30:0], before any flush.
  - With flush active, a flushed subnormal is compared as 0.
  - Ties -> 1.
- Classification and compare are computed combinationally on the input side and registered with the data, never recomputed on the output side.

Decomposition:
- Package fp_pkg:
  - typedef fp32_t: packed struct {sign, exp[7:0], mant[22:0]}.
  - typedef fp_class_t: enum {NORMAL, ZERO, SUB, INF, NAN}.
  - constants EXP_MAX=8'hFF, EXP_BIAS=127, MANT_W=23, EXP_W=8.
  - typedef unpacked_t: the registered per-operand payload.
- Sub-module fp_classify: combinational, one fp32_t in -> fields, hidden bit, fp_class_t out. Instantiated twice inside fp_unpack_stage.

Test Plan:
1. Reset, then A=0x3F800000, B=0xC0000000, out_ready=1:
   - Next cycle: out_valid=1, signA=0, exponentA=0x7F, mantissaA=0, hiddenA=1, signB=1, exponentB=0x80, AgeB=0, all flags 0.
2. A=0x7F800000, B=0x7FC00000:
   - Ainf=1, BNaN=1, hiddenA=hiddenB=0, AgeB=0.
3. A=0x80000000, B=0x00000001, FLUSH_SUBNORMAL=0:
   - Azero=1, signA=1, Bsub=1, mantissaB=1, AgeB=0.
   - Same stimulus with FLUSH_SUBNORMAL=1: Bzero=1, Bsub=0, mantissaB=0, AgeB=1.
4. Backpressure: hold out_ready=0 and stream pairs P0, P1, P2 with in_valid=1:
   - P0 in main, P1 in skid, in_ready=0 from the cycle after P1 is accepted, P2 held by the source.
   - Release out_ready: P0, P1, P2 emerge in order on consecutive cycles, outputs stable while stalled.
5. Continuous stream of 16 random pairs, out_ready=1:
   - One output per cycle at 1-cycle latency; every field matches the scoreboard.
   - Then random out_ready toggling: no loss, duplication or reorder.
6. Assert reset mid-stall with both entries full:
   - Next cycle: out_valid=0, in_ready=1, all outputs 0.
   - The first pair accepted after reset is the first pair output.
